// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
//   Host->pet UART receive path with a single-letter command decoder.
//   An 8N1 deserialiser produces framed bytes; a small decoder turns
//   "<letter><CR|LF>" sequences into one-cycle action pulses.
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   uart_rx     serial input, idle high, asynchronous to clk
//   byte_data   last correctly framed byte (held until the next good byte)
//   byte_valid  1-cycle pulse, byte_data updated this cycle
//   frame_err   1-cycle pulse, stop bit sampled low
//   cmd_feed/play/heal/clean/sleep/dump  1-cycle command pulses (F/P/M/C/S/D)
//   cmd_err     1-cycle pulse: malformed command, framing error mid-command or timeout
module uart_cmd_rx #(
  parameter int DELAY_FRAMES = 234,
  parameter int CMD_TIMEOUT  = 27000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       cmd_feed,
  output logic       cmd_play,
  output logic       cmd_heal,
  output logic       cmd_clean,
  output logic       cmd_sleep,
  output logic       cmd_dump,
  output logic       cmd_err
);
  localparam int CW = $clog2(DELAY_FRAMES);
  localparam int TW = $clog2(CMD_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DELAY_FRAMES / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(CMD_TIMEOUT - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic {CMD_IDLE, CMD_HAVE} cmd_state_t;

  // Two-flop synchroniser; everything downstream uses rx_s_q only.
  logic rx_meta_q, rx_s_q;

  rx_state_t   rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        frame_err_q, frame_err_d;

  cmd_state_t  cmd_state_q, cmd_state_d;
  logic [7:0]  code_q, code_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [5:0]  cmd_vec_q, cmd_vec_d;   // {dump, sleep, clean, heal, play, feed}
  logic        cmd_err_q, cmd_err_d;

  // Receive FSM
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        // Re-check the line mid start bit so short glitches are discarded.
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            bit_d      = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};  // LSB first
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
          else               bit_d      = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_data_d  = shift_q;
            byte_valid_d = 1'b1;
            rx_state_d   = RX_IDLE;
          end else begin
            frame_err_d  = 1'b1;
            rx_state_d   = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        // A held-low line (break) reports a single frame error, then waits here.
        if (rx_s_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Command decoder, driven by the registered byte_valid/frame_err pulses
  logic [7:0] byte_uc;
  logic       is_term, is_cmd;
  assign byte_uc = (byte_data_q >= 8'h61 && byte_data_q <= 8'h7A) ? byte_data_q - 8'h20 : byte_data_q;
  assign is_term = (byte_uc == 8'h0D) || (byte_uc == 8'h0A);
  assign is_cmd  = (byte_uc == 8'h46) || (byte_uc == 8'h50) || (byte_uc == 8'h4D) ||
                   (byte_uc == 8'h43) || (byte_uc == 8'h53) || (byte_uc == 8'h44);

  always_comb begin
    cmd_state_d = cmd_state_q;
    code_d      = code_q;
    tmo_d       = tmo_q;
    cmd_vec_d   = '0;
    cmd_err_d   = 1'b0;
    case (cmd_state_q)
      CMD_IDLE: begin
        // Framing errors while idle are treated as line noise.
        if (byte_valid_q) begin
          if (is_cmd) begin
            code_d      = byte_uc;
            tmo_d       = '0;
            cmd_state_d = CMD_HAVE;
          end else if (!is_term) begin
            cmd_err_d = 1'b1;
          end
        end
      end
      CMD_HAVE: begin
        if (byte_valid_q) begin
          cmd_state_d = CMD_IDLE;
          if (is_term) begin
            cmd_vec_d[0] = (code_q == 8'h46);
            cmd_vec_d[1] = (code_q == 8'h50);
            cmd_vec_d[2] = (code_q == 8'h4D);
            cmd_vec_d[3] = (code_q == 8'h43);
            cmd_vec_d[4] = (code_q == 8'h53);
            cmd_vec_d[5] = (code_q == 8'h44);
          end else begin
            // The offending byte is dropped, not re-parsed as a new letter.
            cmd_err_d = 1'b1;
          end
        end else if (frame_err_q || tmo_q == TMO_LAST) begin
          cmd_err_d   = 1'b1;
          cmd_state_d = CMD_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: cmd_state_d = CMD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      cmd_state_q  <= CMD_IDLE;
      code_q       <= '0;
      tmo_q        <= '0;
      cmd_vec_q    <= '0;
      cmd_err_q    <= 1'b0;
    end else begin
      rx_meta_q    <= uart_rx;
      rx_s_q       <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      cmd_state_q  <= cmd_state_d;
      code_q       <= code_d;
      tmo_q        <= tmo_d;
      cmd_vec_q    <= cmd_vec_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign cmd_feed   = cmd_vec_q[0];
  assign cmd_play   = cmd_vec_q[1];
  assign cmd_heal   = cmd_vec_q[2];
  assign cmd_clean  = cmd_vec_q[3];
  assign cmd_sleep  = cmd_vec_q[4];
  assign cmd_dump   = cmd_vec_q[5];
  assign cmd_err    = cmd_err_q;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx
//   Directed and randomised serial stimulus for uart_cmd_rx, with expected
//   command pulses derived from a byte-level model of the command grammar.
module tb_uart_cmd_rx;
  localparam int DF  = 16;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic [7:0] byte_data;
  logic byte_valid, frame_err, cmd_feed, cmd_play, cmd_heal, cmd_clean, cmd_sleep, cmd_dump, cmd_err;

  uart_cmd_rx #(.DELAY_FRAMES(DF), .CMD_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .byte_data(byte_data), .byte_valid(byte_valid), .frame_err(frame_err),
    .cmd_feed(cmd_feed), .cmd_play(cmd_play), .cmd_heal(cmd_heal),
    .cmd_clean(cmd_clean), .cmd_sleep(cmd_sleep), .cmd_dump(cmd_dump),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every byte / command pulse seen while out of reset.
  logic [7:0] got_bytes[$];
  logic [7:0] got_cmds[$];
  int         lat_q[$];
  int         nferr = 0;
  int         viol  = 0;
  int         last_bv = 0;
  bit         prev_evt = 1'b0;

  always @(negedge clk) begin
    logic [7:0] c;
    if (rst_n === 1'b1) begin
      c = 8'h00;
      if (byte_valid) begin
        got_bytes.push_back(byte_data);
        last_bv = int'(cyc);
      end
      if (frame_err) nferr++;
      if ($countones({cmd_feed, cmd_play, cmd_heal, cmd_clean, cmd_sleep, cmd_dump, cmd_err}) > 1) viol++;
      if (byte_valid && frame_err) viol++;
      if (prev_evt && (byte_valid || frame_err)) viol++;
      prev_evt = byte_valid || frame_err;
      if (cmd_feed)  c = "F";
      if (cmd_play)  c = "P";
      if (cmd_heal)  c = "M";
      if (cmd_clean) c = "C";
      if (cmd_sleep) c = "S";
      if (cmd_dump)  c = "D";
      if (cmd_err)   c = "E";
      if (c != 8'h00) begin
        got_cmds.push_back(c);
        lat_q.push_back(int'(cyc) - last_bv);
      end
    end else begin
      prev_evt = 1'b0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the command grammar, one received event at a time.
  logic [7:0] exp_cmds[$];
  logic [7:0] m_pending = 8'h00;

  task automatic model_event(input bit ferr, input logic [7:0] b);
    logic [7:0] u;
    bit letter, term;
    u = (b >= "a" && b <= "z") ? b - 8'h20 : b;
    letter = (u == "F" || u == "P" || u == "M" || u == "C" || u == "S" || u == "D");
    term = (u == 8'h0D || u == 8'h0A);
    if (m_pending == 8'h00) begin
      if (!ferr) begin
        if (letter) m_pending = u;
        else if (!term) exp_cmds.push_back("E");
      end
    end else begin
      if (!ferr && term) exp_cmds.push_back(m_pending);
      else exp_cmds.push_back("E");
      m_pending = 8'h00;
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (DF) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1);
    repeat (2) @(posedge clk);
    model_event(1'b0, b);
  endtask

  task automatic send_bad(input logic [7:0] b, input int hold);
    send_frame(b, 1'b0);
    repeat (hold) @(posedge clk);
    uart_rx = 1'b1;
    repeat (4) @(posedge clk);
    model_event(1'b1, b);
  endtask

  int cmd_base = 0;

  task automatic compare_cmds(input string tag);
    int n, m;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n = got_cmds.size() - cmd_base;
    check({tag, " cmd count"}, n, exp_cmds.size());
    m = (n < exp_cmds.size()) ? n : exp_cmds.size();
    for (int i = 0; i < m; i++) check({tag, " cmd code"}, got_cmds[cmd_base + i], exp_cmds[i]);
    $display("step %s: cmd pulses=%0d expected=%0d", tag, n, exp_cmds.size());
    cmd_base = got_cmds.size();
    exp_cmds.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " byte_data"}, byte_data, 32'h0);
    check({tag, " pulses"}, {byte_valid, frame_err, cmd_feed, cmd_play, cmd_heal,
                             cmd_clean, cmd_sleep, cmd_dump, cmd_err}, 32'h0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bb, fb;
    logic [7:0] tok [16];
    logic [7:0] b;
    tok[0] = "F"; tok[1] = "f"; tok[2] = "P"; tok[3] = "p";
    tok[4] = "M"; tok[5] = "m"; tok[6] = "C"; tok[7] = "c";
    tok[8] = "S"; tok[9] = "s"; tok[10] = "D"; tok[11] = "d";
    tok[12] = 8'h0D; tok[13] = 8'h0A; tok[14] = "X"; tok[15] = 8'h00;

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Single byte 0x55 (not a command letter, so the decoder flags it)
    bb = got_bytes.size(); fb = nferr;
    send(8'h55);
    @(negedge clk);
    check("b55 count", got_bytes.size() - bb, 1);
    check("b55 data", byte_data, 8'h55);
    check("b55 no ferr", nferr - fb, 0);
    compare_cmds("b55");

    // "f\r\n" -> one feed, one cycle after the CR byte_valid
    send("f"); send(8'h0D); send(8'h0A);
    check("feed latency", lat_q[lat_q.size() - 1], 1);
    compare_cmds("feed");

    // Framing error followed by a long break, then a good byte
    bb = got_bytes.size(); fb = nferr;
    send_bad(8'hA3, 40 * DF);
    check("break ferr", nferr - fb, 1);
    check("break no byte", got_bytes.size() - bb, 0);
    send(8'h41);
    @(negedge clk);
    check("after break data", byte_data, 8'h41);
    compare_cmds("break");

    // "FX\r" -> one error
    send("F"); send("X"); send(8'h0D);
    compare_cmds("FX");

    // Timeout after "D"
    send("D");
    repeat (TMO + 100) @(posedge clk);
    exp_cmds.push_back("E");
    m_pending = 8'h00;
    compare_cmds("timeout");
    send(8'h0D);
    compare_cmds("late CR");

    // 3-cycle glitch
    bb = got_bytes.size(); fb = nferr;
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    check("glitch bytes", got_bytes.size() - bb, 0);
    check("glitch ferr", nferr - fb, 0);
    compare_cmds("glitch");

    // Reset in the middle of "S\r"
    send("S");
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("in reset");
    end
    @(posedge clk);
    rst_n = 1'b1;
    m_pending = 8'h00;
    repeat (20) @(posedge clk);
    compare_cmds("reset abort");
    send("s"); send(8'h0D);
    compare_cmds("after reset");

    // Random bytes
    bb = got_bytes.size();
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      send(b);
      @(negedge clk);
      check("rand byte", byte_data, b);
    end
    check("rand byte count", got_bytes.size() - bb, 12);
    compare_cmds("rand bytes");

    // Random command stream with occasional framing errors
    fb = nferr;
    begin
      int nbad;
      nbad = 0;
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 99) < 8) begin
          send_bad(8'($urandom), 20);
          nbad++;
        end else begin
          send(tok[$urandom_range(0, 15)]);
        end
      end
      check("stream ferr", nferr - fb, nbad);
    end
    compare_cmds("stream");

    check("protocol violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
